pc_gen: RTL



---
 rtl/pc_gen_pkg.sv | 19 +
 rtl/pc_gen_if.sv | 30 +++
 rtl/pc_redirect_arb.sv | 58 +++++
 rtl/pc_gen.sv | 89 ++++++++
 4 files changed

// File: rtl/pc_gen_pkg.sv
// Shared types and constants for the fetch-stage program-counter generator.
package pc_gen_pkg;

    typedef enum logic {
        StBoot,
        StRun
    } state_e;

    localparam logic [63:0] DefaultResetVector = 64'h8000_0000;
    localparam int unsigned DefaultEpochW      = 2;

    typedef logic [DefaultEpochW-1:0] epoch_t;

    // Number of PC low bits that must be zero for a given instruction alignment.
    function automatic int unsigned align_bits(input int unsigned ialign);
        return (ialign == 2) ? 1 : 2;
    endfunction

endpackage

// File: rtl/pc_gen_if.sv
// Redirect, fetch-handshake and PC-offer signals between pc_gen and its neighbours.
interface pc_gen_if #(
    parameter int unsigned XLEN    = 64,
    parameter int unsigned EPOCH_W = 2
);
    logic               trap_i_valid;
    logic [XLEN-1:0]    trap_i_pc;
    logic               execute_i_need_jump;
    logic [XLEN-1:0]    execute_i_jump_pc;
    logic               fetch_i_pre_valid;
    logic [XLEN-1:0]    fetch_i_pre_pc;
    logic               fetch_i_ready;
    logic [XLEN-1:0]    pc;
    logic               pc_valid;
    logic [EPOCH_W-1:0] pc_epoch;
    logic               redirect_o_flush;
    logic               pc_o_misalign;

    modport master (
        input  trap_i_valid, trap_i_pc, execute_i_need_jump, execute_i_jump_pc,
        input  fetch_i_pre_valid, fetch_i_pre_pc, fetch_i_ready,
        output pc, pc_valid, pc_epoch, redirect_o_flush, pc_o_misalign
    );

    modport slave (
        output trap_i_valid, trap_i_pc, execute_i_need_jump, execute_i_jump_pc,
        output fetch_i_pre_valid, fetch_i_pre_pc, fetch_i_ready,
        input  pc, pc_valid, pc_epoch, redirect_o_flush, pc_o_misalign
    );
endinterface

// File: rtl/pc_redirect_arb.sv
// Combinational next-PC selection: trap > execute > prediction > sequential > hold,
// with target alignment and redirect-class / misalign flags.
module pc_redirect_arb
    import pc_gen_pkg::*;
#(
    parameter int unsigned XLEN   = 64,
    parameter int unsigned IALIGN = 4
) (
    input  logic            i_trap_valid,
    input  logic [XLEN-1:0] i_trap_pc,
    input  logic            i_exec_jump,
    input  logic [XLEN-1:0] i_exec_pc,
    input  logic            i_pre_valid,
    input  logic [XLEN-1:0] i_pre_pc,
    input  logic            i_handshake,
    input  logic [XLEN-1:0] i_pc,
    output logic            o_load,
    output logic [XLEN-1:0] o_target,
    output logic            o_redirect,
    output logic            o_misalign
);
    localparam int unsigned     AlignBits = align_bits(IALIGN);
    localparam logic [XLEN-1:0] AlignMask = XLEN'((1 << AlignBits) - 1);
    localparam logic [XLEN-1:0] Step      = XLEN'(IALIGN);

    logic [XLEN-1:0] w_raw;
    logic            w_is_target;

    always_comb begin
        w_raw       = i_pc;
        w_is_target = 1'b0;
        o_redirect  = 1'b0;
        o_load      = 1'b0;
        if (i_trap_valid) begin
            w_raw       = i_trap_pc;
            w_is_target = 1'b1;
            o_redirect  = 1'b1;
            o_load      = 1'b1;
        end else if (i_exec_jump) begin
            w_raw       = i_exec_pc;
            w_is_target = 1'b1;
            o_redirect  = 1'b1;
            o_load      = 1'b1;
        end else if (i_handshake && i_pre_valid) begin
            w_raw       = i_pre_pc;
            w_is_target = 1'b1;
            o_load      = 1'b1;
        end else if (i_handshake) begin
            w_raw  = i_pc + Step;
            o_load = 1'b1;
        end
    end

    // Sequential PCs are already aligned, so masking them is harmless.
    assign o_target   = w_raw & ~AlignMask;
    assign o_misalign = w_is_target && ((w_raw & AlignMask) != '0);

endmodule

// File: rtl/pc_gen.sv
// Fetch PC generator: holds the PC, advances it on the fetch handshake and
// applies epoch-tagged trap/execute redirects and fetch-prediction redirects.
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int unsigned XLEN         = 64,
    parameter logic [63:0] RESET_VECTOR = DefaultResetVector,
    parameter int unsigned IALIGN       = 4,
    parameter int unsigned EPOCH_W      = 2
) (
    input logic      clk,
    input logic      rst,
    pc_gen_if.master bus
);
    localparam logic [XLEN-1:0] ResetPc = RESET_VECTOR[XLEN-1:0];

    state_e             r_state;
    state_e             w_state_next;
    logic [XLEN-1:0]    r_pc;
    logic               r_pc_valid;
    logic [EPOCH_W-1:0] r_epoch;
    logic               r_flush;
    logic               r_misalign;

    logic               w_handshake;
    logic               w_load;
    logic [XLEN-1:0]    w_target;
    logic               w_redirect;
    logic               w_misalign;

    assign w_handshake = r_pc_valid && bus.fetch_i_ready;

    pc_redirect_arb #(
        .XLEN   (XLEN),
        .IALIGN (IALIGN)
    ) u_arb (
        .i_trap_valid (bus.trap_i_valid),
        .i_trap_pc    (bus.trap_i_pc),
        .i_exec_jump  (bus.execute_i_need_jump),
        .i_exec_pc    (bus.execute_i_jump_pc),
        .i_pre_valid  (bus.fetch_i_pre_valid),
        .i_pre_pc     (bus.fetch_i_pre_pc),
        .i_handshake  (w_handshake),
        .i_pc         (r_pc),
        .o_load       (w_load),
        .o_target     (w_target),
        .o_redirect   (w_redirect),
        .o_misalign   (w_misalign)
    );

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StBoot:  w_state_next = StRun;
            StRun:   w_state_next = StRun;
            default: w_state_next = StBoot;
        endcase
    end

    // Redirects act in BOOT too; the handshake cannot, since pc_valid is low there.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= StBoot;
            r_pc       <= ResetPc;
            r_pc_valid <= 1'b0;
            r_epoch    <= '0;
            r_flush    <= 1'b0;
            r_misalign <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_pc_valid <= (w_state_next == StRun);
            if (w_load) begin
                r_pc <= w_target;
            end
            if (w_redirect) begin
                r_epoch <= r_epoch + EPOCH_W'(1);
            end
            r_flush    <= w_redirect;
            r_misalign <= w_misalign;
        end
    end

    assign bus.pc               = r_pc;
    assign bus.pc_valid         = r_pc_valid;
    assign bus.pc_epoch         = r_epoch;
    assign bus.redirect_o_flush = r_flush;
    assign bus.pc_o_misalign    = r_misalign;

endmodule
